mor1kx_axi4lite_arbiter: RTL and testbench
==========================================

MOR1KX_AXI4LITE_ARBITER -- requirements
Module: mor1kx_axi4lite_arbiter

Interface
REQ-001 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 slave_i  AXI_LITE.in  interface-parameterised  instruction-side AXI4-Lite port (port 0).
REQ-004 slave_d  AXI_LITE.in  interface-parameterised  data-side AXI4-Lite port (port 1).
REQ-005 master  AXI_LITE.out  interface-parameterised  merged AXI4-Lite port toward the system interconnect.
REQ-006 All three ports SHALL have identical AXI_ADDR_WIDTH and AXI_DATA_WIDTH; strobe width SHALL be AXI_DATA_WIDTH/8.

Function
REQ-007 The block SHALL allow exactly one transaction in flight at a time, across both ports and both directions.
REQ-008 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-009 A port SHALL request a read when ar_valid=1; it SHALL request a write only when aw_valid=1 and w_valid=1 together.
REQ-010 Within one port, a pending read SHALL take priority over a pending write.
REQ-011 Between ports, a single requester SHALL be granted. On simultaneous requests, the port not granted last SHALL win. last_grant SHALL reset to port 1, so port 0 wins the first tie.
REQ-012 In IDLE with a grant, the block SHALL pulse the granted port's ar_ready (read) or aw_ready+w_ready (write) for one cycle. It SHALL latch addr/data/strb and the grant index, update last_grant, and move to RD_ADDR or WR_REQ.
REQ-013 master.ar_valid SHALL assert the cycle after slave acceptance, with the latched address, and hold until master.ar_ready. The state then SHALL go RD_ADDR->RD_DATA.
REQ-014 In RD_DATA, the block SHALL route combinationally: granted r_valid=master.r_valid, r_data/r_resp passed unchanged, master.r_ready=granted r_ready. On that handshake the state SHALL return to IDLE.
REQ-015 In WR_REQ, master.aw_valid and master.w_valid SHALL assert together. Each SHALL drop independently after its own ready handshake, tracked by flags aw_done/w_done. When both are done, the state SHALL go to WR_RESP. Handshakes in the same cycle or in either order SHALL be legal.
REQ-016 In WR_RESP, b_valid/b_resp SHALL route combinationally to the granted port and b_ready back. On that handshake the state SHALL return to IDLE.
REQ-017 The non-granted port SHALL see all ready and valid outputs at 0. Its requests SHALL wait untouched.
REQ-018 SLVERR/DECERR responses SHALL pass through unmodified. No retry or timeout SHALL be applied.
REQ-019 Minimum request-to-master-valid latency SHALL be 1 cycle. The earliest next acceptance SHALL be the cycle after the response handshake.

Reset
REQ-020 On rst_i=1 at a clock edge: state=IDLE, last_grant=1, aw_done=w_done=0, latched addr/data/strb=0.
REQ-021 During and after reset, all master valid/ready outputs and all slave ready/valid outputs SHALL be 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction without completing the response. A global reset of downstream slaves is the system contract.

Structure
REQ-023 Package mor1kx_axi4lite_arb_pkg SHALL hold the FSM state enum, PORT_I=0/PORT_D=1 constants, and the request-type enum (NONE/READ/WRITE).
REQ-024 A 2-input round-robin grant sub-module axi4lite_rr_arb2 SHALL be used: inputs req[1:0], last_grant; output grant index and grant-valid; purely combinational.
REQ-025 The block SHALL sit between the instruction/data AXI4-Lite bridges and the interconnect, and SHALL contain no other sub-modules.

Verification
REQ-026 Read on port 0 only: addr 0x0000_1000; slave returns 0xDEADBEEF/OKAY after 3 cycles -> master.ar_valid 1 cycle after accept; slave_i gets 0xDEADBEEF, OKAY; slave_d sees no activity.
REQ-027 Simultaneous reads on both ports after reset -> port 0 served first, port 1 second. A repeated tie then serves port 1 first.
REQ-028 Write on port 1: addr 0x10, data 0xA5A5A5A5, strb 0x3; master aw_ready asserted 2 cycles before w_ready -> one aw and one w handshake, each carrying the exact values; slave_d gets b_resp OKAY; state goes IDLE->WR_REQ->WR_RESP->IDLE.
REQ-029 Port 0 asserts ar_valid and aw_valid+w_valid together -> read completes first, then the write.
REQ-030 Master returns SLVERR on a port-1 read -> slave_d r_resp=2'b10 unchanged.
REQ-031 rst_i pulsed while in RD_DATA -> next cycle all valid/ready outputs are 0 and state is IDLE; a new port-1 read then completes normally.

Source files
------------

// File: rtl/mor1kx_axi4lite_arb_pkg.sv
// mor1kx_axi4lite_arb_pkg: shared types, channel bundles and port constants for the AXI4-Lite arbiter
package mor1kx_axi4lite_arb_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
  typedef enum logic [1:0] {NONE, READ, WRITE} req_t;
  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic                      aw_valid;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_valid;
    logic                      b_ready;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic                      ar_valid;
    logic                      r_ready;
  } axi_req_t;
  typedef struct packed {
    logic                      aw_ready;
    logic                      w_ready;
    logic [1:0]                b_resp;
    logic                      b_valid;
    logic                      ar_ready;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_valid;
  } axi_rsp_t;
  function automatic req_t req_kind(input axi_req_t r);
    return r.ar_valid ? READ : (r.aw_valid && r.w_valid) ? WRITE : NONE;
  endfunction
endpackage

// File: rtl/axi4lite_rr_arb2.sv
// axi4lite_rr_arb2: combinational 2-way round-robin grant
// Ports: req[1:0] requesters, last_grant previous winner; grant winning index, grant_valid any request.
module axi4lite_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);
  assign grant_valid = |req;
  assign grant = &req ? ~last_grant : req[1];
endmodule

// File: rtl/mor1kx_axi4lite_arbiter.sv
// mor1kx_axi4lite_arbiter: merges instruction/data AXI4-Lite ports onto one master, one transaction in flight
// Ports: clk_i, rst_i (sync active-high); slave_i_* port 0 and slave_d_* port 1 (req in, rsp out);
// master_req out / master_rsp in toward the interconnect.
module mor1kx_axi4lite_arbiter
  import mor1kx_axi4lite_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t slave_i_req,
  output axi_rsp_t slave_i_rsp,
  input  axi_req_t slave_d_req,
  output axi_rsp_t slave_d_rsp,
  output axi_req_t master_req,
  input  axi_rsp_t master_rsp
);
  state_t state, next, cur;
  req_t kind;
  logic last_grant, gnt, grant, grant_valid, accept, aw_done, w_done, aw_fin, w_fin;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [AXI_DATA_WIDTH-1:0] data;
  logic [AXI_STRB_WIDTH-1:0] strb;
  axi_req_t s_req [2];
  axi_rsp_t s_rsp [2];
  assign s_req[PORT_I] = slave_i_req;
  assign s_req[PORT_D] = slave_d_req;
  assign slave_i_rsp = s_rsp[PORT_I];
  assign slave_d_rsp = s_rsp[PORT_D];
  axi4lite_rr_arb2 u_arb (
    .req({req_kind(s_req[1]) != NONE, req_kind(s_req[0]) != NONE}),
    .last_grant(last_grant),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  assign kind = req_kind(s_req[grant]);
  // Outputs decode from cur so every valid/ready is already low while reset is held.
  assign cur = rst_i ? IDLE : state;
  assign accept = !rst_i && state == IDLE && grant_valid;
  assign aw_fin = aw_done || master_rsp.aw_ready;
  assign w_fin = w_done || master_rsp.w_ready;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? (kind == READ ? RD_ADDR : WR_REQ) : IDLE;
      RD_ADDR: next = master_rsp.ar_ready ? RD_DATA : RD_ADDR;
      RD_DATA: next = (master_rsp.r_valid && s_req[gnt].r_ready) ? IDLE : RD_DATA;
      WR_REQ:  next = (aw_fin && w_fin) ? WR_RESP : WR_REQ;
      WR_RESP: next = (master_rsp.b_valid && s_req[gnt].b_ready) ? IDLE : WR_RESP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    master_req = '0;
    master_req.aw_addr = addr;
    master_req.ar_addr = addr;
    master_req.w_data = data;
    master_req.w_strb = strb;
    master_req.ar_valid = cur == RD_ADDR;
    master_req.aw_valid = cur == WR_REQ && !aw_done;
    master_req.w_valid = cur == WR_REQ && !w_done;
    master_req.r_ready = cur == RD_DATA && s_req[gnt].r_ready;
    master_req.b_ready = cur == WR_RESP && s_req[gnt].b_ready;
  end
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s_rsp[i] = '0;
      s_rsp[i].r_data = master_rsp.r_data;
      s_rsp[i].r_resp = master_rsp.r_resp;
      s_rsp[i].b_resp = master_rsp.b_resp;
      s_rsp[i].ar_ready = accept && grant == 1'(i) && kind == READ;
      s_rsp[i].aw_ready = accept && grant == 1'(i) && kind == WRITE;
      s_rsp[i].w_ready = accept && grant == 1'(i) && kind == WRITE;
      s_rsp[i].r_valid = cur == RD_DATA && gnt == 1'(i) && master_rsp.r_valid;
      s_rsp[i].b_valid = cur == WR_RESP && gnt == 1'(i) && master_rsp.b_valid;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last_grant <= PORT_D;
      gnt <= PORT_I;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      addr <= '0;
      data <= '0;
      strb <= '0;
    end else begin
      state <= next;
      // Done flags only live inside WR_REQ; they clear as the write moves on to its response.
      aw_done <= state == WR_REQ && next == WR_REQ && aw_fin;
      w_done <= state == WR_REQ && next == WR_REQ && w_fin;
      if (accept) begin
        gnt <= grant;
        last_grant <= grant;
        addr <= kind == READ ? s_req[grant].ar_addr : s_req[grant].aw_addr;
        if (kind == WRITE) begin
          data <= s_req[grant].w_data;
          strb <= s_req[grant].w_strb;
        end
      end
    end
  end
endmodule

// File: tb/tb_mor1kx_axi4lite_arbiter.sv
// tb_mor1kx_axi4lite_arbiter: directed self-checking bench for the AXI4-Lite arbiter
module tb_mor1kx_axi4lite_arbiter;
  import mor1kx_axi4lite_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  axi_req_t s_req [2];
  axi_rsp_t s_rsp [2];
  axi_req_t m_req;
  axi_rsp_t m_rsp;
  int checks = 0;
  int errors = 0;
  int aw_hs = 0;
  int w_hs = 0;
  logic [31:0] cap_aw = '0;
  logic [31:0] cap_w = '0;
  logic [3:0] cap_strb = '0;
  always #5 clk = ~clk;
  mor1kx_axi4lite_arbiter dut (
    .clk_i(clk),
    .rst_i(rst),
    .slave_i_req(s_req[0]),
    .slave_i_rsp(s_rsp[0]),
    .slave_d_req(s_req[1]),
    .slave_d_rsp(s_rsp[1]),
    .master_req(m_req),
    .master_rsp(m_rsp)
  );
  always @(posedge clk) begin
    if (m_req.aw_valid && m_rsp.aw_ready) begin
      aw_hs = aw_hs + 1;
      cap_aw = m_req.aw_addr;
    end
    if (m_req.w_valid && m_rsp.w_ready) begin
      w_hs = w_hs + 1;
      cap_w = m_req.w_data;
      cap_strb = m_req.w_strb;
    end
  end
  function automatic logic busy(input axi_rsp_t r);
    return r.ar_ready | r.aw_ready | r.w_ready | r.r_valid | r.b_valid;
  endfunction
  task automatic serve_read(input int p, input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr, input int lat);
    int o = 1 - p;
    @(negedge clk); s_req[p].ar_valid = 1'b0; #1;
    checks++; if (m_req.ar_valid !== 1'b1 || m_req.ar_addr !== a) begin errors++; $display("FAIL ar_issue p%0d got v=%b a=%h exp v=1 a=%h", p, m_req.ar_valid, m_req.ar_addr, a); end
    checks++; if (busy(s_rsp[p]) !== 1'b0 || busy(s_rsp[o]) !== 1'b0) begin errors++; $display("FAIL rd_addr_quiet p%0d got %b/%b exp 0/0", p, busy(s_rsp[p]), busy(s_rsp[o])); end
    m_rsp.ar_ready = 1'b1;
    @(negedge clk); m_rsp.ar_ready = 1'b0; #1;
    checks++; if (m_req.ar_valid !== 1'b0 || dut.state !== RD_DATA) begin errors++; $display("FAIL ar_done p%0d got v=%b st=%0d exp v=0 st=%0d", p, m_req.ar_valid, dut.state, RD_DATA); end
    repeat (lat) begin
      @(negedge clk); #1;
      checks++; if (s_rsp[p].r_valid !== 1'b0) begin errors++; $display("FAIL r_early p%0d got %b exp 0", p, s_rsp[p].r_valid); end
    end
    m_rsp.r_valid = 1'b1; m_rsp.r_data = d; m_rsp.r_resp = rr; #1;
    checks++; if (s_rsp[p].r_valid !== 1'b1 || s_rsp[p].r_data !== d || s_rsp[p].r_resp !== rr) begin errors++; $display("FAIL r_route p%0d got v=%b d=%h r=%b exp v=1 d=%h r=%b", p, s_rsp[p].r_valid, s_rsp[p].r_data, s_rsp[p].r_resp, d, rr); end
    checks++; if (m_req.r_ready !== 1'b1) begin errors++; $display("FAIL r_ready p%0d got %b exp 1", p, m_req.r_ready); end
    checks++; if (busy(s_rsp[o]) !== 1'b0) begin errors++; $display("FAIL r_other_quiet p%0d got %b exp 0", o, busy(s_rsp[o])); end
    @(negedge clk); m_rsp.r_valid = 1'b0; #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rd_end_idle got %0d exp %0d", dut.state, IDLE); end
  endtask
  task automatic serve_write(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] br, input int gap);
    int o = 1 - p;
    @(negedge clk); s_req[p].aw_valid = 1'b0; s_req[p].w_valid = 1'b0; aw_hs = 0; w_hs = 0; #1;
    checks++; if (dut.state !== WR_REQ) begin errors++; $display("FAIL wr_state got %0d exp %0d", dut.state, WR_REQ); end
    checks++; if (m_req.aw_valid !== 1'b1 || m_req.w_valid !== 1'b1) begin errors++; $display("FAIL wr_valids got aw=%b w=%b exp 1/1", m_req.aw_valid, m_req.w_valid); end
    checks++; if (m_req.aw_addr !== a || m_req.w_data !== d || m_req.w_strb !== s) begin errors++; $display("FAIL wr_payload got %h/%h/%h exp %h/%h/%h", m_req.aw_addr, m_req.w_data, m_req.w_strb, a, d, s); end
    for (int c = 0; c <= gap; c++) begin
      if (c > 0) begin
        @(negedge clk); m_rsp.aw_ready = 1'b0; #1;
        checks++; if (m_req.aw_valid !== 1'b0 || m_req.w_valid !== 1'b1) begin errors++; $display("FAIL wr_split got aw=%b w=%b exp 0/1", m_req.aw_valid, m_req.w_valid); end
      end
      if (c == 0) m_rsp.aw_ready = 1'b1;
      if (c == gap) m_rsp.w_ready = 1'b1;
    end
    @(negedge clk); m_rsp.aw_ready = 1'b0; m_rsp.w_ready = 1'b0; #1;
    checks++; if (dut.state !== WR_RESP || m_req.aw_valid !== 1'b0 || m_req.w_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_state got st=%0d aw=%b w=%b exp st=%0d 0/0", dut.state, m_req.aw_valid, m_req.w_valid, WR_RESP); end
    checks++; if (aw_hs !== 1 || w_hs !== 1) begin errors++; $display("FAIL wr_hs_count got aw=%0d w=%0d exp 1/1", aw_hs, w_hs); end
    checks++; if (cap_aw !== a || cap_w !== d || cap_strb !== s) begin errors++; $display("FAIL wr_hs_values got %h/%h/%h exp %h/%h/%h", cap_aw, cap_w, cap_strb, a, d, s); end
    m_rsp.b_valid = 1'b1; m_rsp.b_resp = br; #1;
    checks++; if (s_rsp[p].b_valid !== 1'b1 || s_rsp[p].b_resp !== br || m_req.b_ready !== 1'b1) begin errors++; $display("FAIL b_route p%0d got v=%b r=%b rdy=%b exp 1 %b 1", p, s_rsp[p].b_valid, s_rsp[p].b_resp, m_req.b_ready, br); end
    checks++; if (busy(s_rsp[o]) !== 1'b0) begin errors++; $display("FAIL b_other_quiet p%0d got %b exp 0", o, busy(s_rsp[o])); end
    @(negedge clk); m_rsp.b_valid = 1'b0; #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL wr_end_idle got %0d exp %0d", dut.state, IDLE); end
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_reset();
    s_req[0].ar_valid = 1'b1; s_req[1].aw_valid = 1'b1; s_req[1].w_valid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (busy(s_rsp[0]) !== 1'b0 || busy(s_rsp[1]) !== 1'b0) begin errors++; $display("FAIL rst_slave_quiet got %b/%b exp 0/0", busy(s_rsp[0]), busy(s_rsp[1])); end
    checks++; if ({m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.r_ready, m_req.b_ready} !== 5'b0) begin errors++; $display("FAIL rst_master_quiet got %b exp 00000", {m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.r_ready, m_req.b_ready}); end
    checks++; if (dut.state !== IDLE || dut.last_grant !== 1'b1 || dut.addr !== 32'h0) begin errors++; $display("FAIL rst_state got st=%0d lg=%b a=%h exp %0d 1 0", dut.state, dut.last_grant, dut.addr, IDLE); end
    s_req[0].ar_valid = 1'b0; s_req[1].aw_valid = 1'b0; s_req[1].w_valid = 1'b0; rst = 1'b0;
  endtask
  task automatic test_read_port0();
    @(negedge clk); s_req[0].ar_valid = 1'b1; s_req[0].ar_addr = 32'h0000_1000; #1;
    checks++; if (s_rsp[0].ar_ready !== 1'b1 || m_req.ar_valid !== 1'b0) begin errors++; $display("FAIL rd0_accept got rdy=%b mv=%b exp 1/0", s_rsp[0].ar_ready, m_req.ar_valid); end
    serve_read(0, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 3);
  endtask
  task automatic test_tie();
    do_reset();
    s_req[0].ar_valid = 1'b1; s_req[0].ar_addr = 32'h100; s_req[1].ar_valid = 1'b1; s_req[1].ar_addr = 32'h200; #1;
    checks++; if (s_rsp[0].ar_ready !== 1'b1 || s_rsp[1].ar_ready !== 1'b0) begin errors++; $display("FAIL tie1 got %b/%b exp 1/0", s_rsp[0].ar_ready, s_rsp[1].ar_ready); end
    serve_read(0, 32'h100, 32'h1111_0000, 2'b00, 1);
    s_req[0].ar_valid = 1'b1; s_req[0].ar_addr = 32'h300; #1;
    checks++; if (s_rsp[0].ar_ready !== 1'b0 || s_rsp[1].ar_ready !== 1'b1) begin errors++; $display("FAIL tie2 got %b/%b exp 0/1", s_rsp[0].ar_ready, s_rsp[1].ar_ready); end
    serve_read(1, 32'h200, 32'h2222_0000, 2'b00, 0);
    #1;
    checks++; if (s_rsp[0].ar_ready !== 1'b1) begin errors++; $display("FAIL tie3 got %b exp 1", s_rsp[0].ar_ready); end
    serve_read(0, 32'h300, 32'h3333_0000, 2'b00, 0);
  endtask
  task automatic test_write_port1();
    @(negedge clk);
    s_req[1].aw_valid = 1'b1; s_req[1].w_valid = 1'b1; s_req[1].aw_addr = 32'h10; s_req[1].w_data = 32'hA5A5_A5A5; s_req[1].w_strb = 4'h3; #1;
    checks++; if (s_rsp[1].aw_ready !== 1'b1 || s_rsp[1].w_ready !== 1'b1 || dut.state !== IDLE) begin errors++; $display("FAIL wr1_accept got %b%b st=%0d exp 11 st=%0d", s_rsp[1].aw_ready, s_rsp[1].w_ready, dut.state, IDLE); end
    serve_write(1, 32'h10, 32'hA5A5_A5A5, 4'h3, 2'b00, 2);
  endtask
  task automatic test_read_before_write();
    @(negedge clk);
    s_req[0].ar_valid = 1'b1; s_req[0].ar_addr = 32'h44;
    s_req[0].aw_valid = 1'b1; s_req[0].w_valid = 1'b1; s_req[0].aw_addr = 32'h88; s_req[0].w_data = 32'h0BAD_F00D; s_req[0].w_strb = 4'hF; #1;
    checks++; if (s_rsp[0].ar_ready !== 1'b1 || s_rsp[0].aw_ready !== 1'b0 || s_rsp[0].w_ready !== 1'b0) begin errors++; $display("FAIL rw_prio got ar=%b aw=%b w=%b exp 1 0 0", s_rsp[0].ar_ready, s_rsp[0].aw_ready, s_rsp[0].w_ready); end
    serve_read(0, 32'h44, 32'hCAFE_0001, 2'b00, 0);
    #1;
    checks++; if (s_rsp[0].aw_ready !== 1'b1 || s_rsp[0].w_ready !== 1'b1) begin errors++; $display("FAIL rw_then_write got %b%b exp 11", s_rsp[0].aw_ready, s_rsp[0].w_ready); end
    serve_write(0, 32'h88, 32'h0BAD_F00D, 4'hF, 2'b00, 0);
  endtask
  task automatic test_slverr();
    @(negedge clk); s_req[1].ar_valid = 1'b1; s_req[1].ar_addr = 32'h20; #1;
    checks++; if (s_rsp[1].ar_ready !== 1'b1) begin errors++; $display("FAIL err_accept got %b exp 1", s_rsp[1].ar_ready); end
    serve_read(1, 32'h20, 32'h0000_0BAD, 2'b10, 1);
  endtask
  task automatic test_reset_mid();
    @(negedge clk); s_req[0].ar_valid = 1'b1; s_req[0].ar_addr = 32'h40; #1;
    checks++; if (s_rsp[0].ar_ready !== 1'b1) begin errors++; $display("FAIL mid_accept got %b exp 1", s_rsp[0].ar_ready); end
    @(negedge clk); s_req[0].ar_valid = 1'b0; m_rsp.ar_ready = 1'b1;
    @(negedge clk); m_rsp.ar_ready = 1'b0; #1;
    checks++; if (dut.state !== RD_DATA) begin errors++; $display("FAIL mid_rd_data got %0d exp %0d", dut.state, RD_DATA); end
    rst = 1'b1; #1;
    checks++; if (m_req.r_ready !== 1'b0 || busy(s_rsp[0]) !== 1'b0) begin errors++; $display("FAIL mid_during_rst got rdy=%b busy=%b exp 0/0", m_req.r_ready, busy(s_rsp[0])); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (dut.state !== IDLE || dut.last_grant !== 1'b1) begin errors++; $display("FAIL mid_state got st=%0d lg=%b exp %0d 1", dut.state, dut.last_grant, IDLE); end
    checks++; if ({m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.r_ready, m_req.b_ready, busy(s_rsp[0]), busy(s_rsp[1])} !== 7'b0) begin errors++; $display("FAIL mid_quiet got %b exp 0000000", {m_req.ar_valid, m_req.aw_valid, m_req.w_valid, m_req.r_ready, m_req.b_ready, busy(s_rsp[0]), busy(s_rsp[1])}); end
    s_req[1].ar_valid = 1'b1; s_req[1].ar_addr = 32'h80; #1;
    checks++; if (s_rsp[1].ar_ready !== 1'b1) begin errors++; $display("FAIL mid_new_accept got %b exp 1", s_rsp[1].ar_ready); end
    serve_read(1, 32'h80, 32'h1234_5678, 2'b00, 0);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      s_req[i] = '0;
      s_req[i].r_ready = 1'b1;
      s_req[i].b_ready = 1'b1;
    end
    m_rsp = '0;
    test_reset();
    test_read_port0();
    test_tie();
    test_write_port1();
    test_read_before_write();
    test_slverr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
